// File: rtl/iic_pkg.sv
// Shared definitions for the IIC command-queue register block.
// Holds register offsets, status/ctrl/action bit positions and FSM states.
package iic_pkg;

    localparam logic [15:0] REG_DEVID     = 16'h0000;
    localparam logic [15:0] REG_STATUS    = 16'h0001;
    localparam logic [15:0] REG_CFG_DEVID = 16'h0002;
    localparam logic [15:0] REG_CFG_ADDR  = 16'h0003;
    localparam logic [15:0] REG_CFG_WDATA = 16'h0004;
    localparam logic [15:0] REG_RDATA     = 16'h0005;
    localparam logic [15:0] REG_PUSH_WR   = 16'h0006;
    localparam logic [15:0] REG_PUSH_RD   = 16'h0007;
    localparam logic [15:0] REG_CFG_CH    = 16'h0008;
    localparam logic [15:0] REG_CTRL      = 16'h0009;
    localparam logic [15:0] REG_QCOUNT    = 16'h000A;
    localparam logic [15:0] REG_DCOUNT    = 16'h000B;
    localparam logic [15:0] REG_ACTION    = 16'h000C;
    localparam logic [15:0] REG_DBG_BASE  = 16'h0080;

    localparam int ST_BUSY    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_NACK    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_DONE    = 5;
    localparam int ST_HALTED  = 6;

    localparam int CTRL_HALT  = 0;
    localparam int CTRL_IRQEN = 1;

    localparam int ACT_FLUSH  = 0;
    localparam int ACT_CLR    = 1;
    localparam int ACT_RESUME = 2;

    localparam int CMD_W      = 33;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/iic_cmdq_fifo.sv
// Synchronous command FIFO with pointer wrap, flush and occupancy count.
// Ports: i_clk/i_rst, i_flush, i_push/i_wdata, i_pop, o_rdata (head), o_count/o_empty/o_full.
module iic_cmdq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    // A full queue drops the push even if a pop happens on the same edge.
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iic_cmdq_reg.sv
// IIC command-queue register block: bus-mapped config, command FIFO and issue FSM.
// Ports: clk/rst, fx_* register bus, cmd_* valid/ready to the engine, rsp_* completion, irq.
module iic_cmdq_reg
    import iic_pkg::*;
#(
    parameter  int QDEPTH = 8,
    parameter  int NCH    = 1,
    parameter  int NDBG   = 8,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           i_clk_sys,
    input  logic           i_rst,
    input  logic [5:0]     i_dev_id,
    input  logic           i_fx_wr,
    input  logic [21:0]    i_fx_waddr,
    input  logic [7:0]     i_fx_data,
    input  logic           i_fx_rd,
    input  logic [21:0]    i_fx_raddr,
    output logic [7:0]     o_fx_q,
    output logic           o_cmd_valid,
    input  logic           i_cmd_ready,
    output logic           o_cmd_rw,
    output logic [CHW-1:0] o_cmd_ch,
    output logic [7:0]     o_cmd_devid,
    output logic [7:0]     o_cmd_addr,
    output logic [7:0]     o_cmd_wdata,
    input  logic           i_rsp_valid,
    input  logic [7:0]     i_rsp_rdata,
    input  logic           i_rsp_nack,
    output logic           o_irq
);
    localparam int CW     = $clog2(QDEPTH) + 1;
    localparam int NDBG_A = (NDBG > 0) ? NDBG : 1;

    state_t           r_state;
    logic             r_own;
    logic [7:0]       r_cfg_devid, r_cfg_addr, r_cfg_wdata, r_last, r_dcnt;
    logic [CHW-1:0]   r_cfg_ch;
    logic             r_halt_en, r_irq_en, r_s_nack, r_s_ovf, r_s_done, r_halted;
    logic [7:0]       r_dbg [NDBG_A];

    logic             w_wsel, w_rsel, w_push, w_flush, w_clr, w_resume;
    logic [15:0]      w_woff, w_roff;
    logic             w_hs, w_done, w_nack_ev, w_ovf_ev;
    logic [CMD_W-1:0] w_push_data, w_head;
    logic [CW-1:0]    w_count;
    logic             w_empty, w_full;
    logic [7:0]       w_status, w_rdata;
    logic             w_unused_head;

    assign w_wsel    = i_fx_wr && (i_fx_waddr[21:16] == i_dev_id);
    assign w_rsel    = i_fx_rd && (i_fx_raddr[21:16] == i_dev_id);
    assign w_woff    = i_fx_waddr[15:0];
    assign w_roff    = i_fx_raddr[15:0];
    assign w_push    = w_wsel && i_fx_data[0]
                     && (w_woff == REG_PUSH_WR || w_woff == REG_PUSH_RD);
    assign w_flush   = w_wsel && (w_woff == REG_ACTION) && i_fx_data[ACT_FLUSH];
    assign w_clr     = w_wsel && (w_woff == REG_ACTION) && i_fx_data[ACT_CLR];
    assign w_resume  = w_wsel && (w_woff == REG_ACTION) && i_fx_data[ACT_RESUME];
    assign w_push_data = {(w_woff == REG_PUSH_RD), {(8-CHW){1'b0}}, r_cfg_ch,
                          r_cfg_devid, r_cfg_addr, r_cfg_wdata};
    assign w_hs      = (r_state == S_ISSUE) && i_cmd_ready;
    assign w_done    = (r_state == S_WAIT) && i_rsp_valid;
    assign w_nack_ev = w_done && i_rsp_nack;
    assign w_ovf_ev  = w_push && w_full && !w_flush;
    assign o_irq     = r_irq_en & (r_s_done | r_s_nack | r_s_ovf);
    assign w_unused_head = ^w_head[31:24];

    iic_cmdq_fifo #(.DEPTH(QDEPTH), .W(CMD_W)) u_fifo (
        .i_clk   (i_clk_sys),
        .i_rst   (i_rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        // A flushed head is no longer ours to pop when its handshake arrives.
        .i_pop   (w_hs && r_own),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_own       <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd_rw    <= 1'b0;
            o_cmd_ch    <= '0;
            o_cmd_devid <= '0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty && !r_halted && !w_flush) begin
                        r_state     <= S_ISSUE;
                        r_own       <= 1'b1;
                        o_cmd_valid <= 1'b1;
                        o_cmd_rw    <= w_head[32];
                        o_cmd_ch    <= w_head[24 +: CHW];
                        o_cmd_devid <= w_head[23:16];
                        o_cmd_addr  <= w_head[15:8];
                        o_cmd_wdata <= w_head[7:0];
                    end
                end
                S_ISSUE: begin
                    if (w_flush) r_own <= 1'b0;
                    if (i_cmd_ready) begin
                        r_state     <= S_WAIT;
                        o_cmd_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_rsp_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_cfg_devid <= 8'h42;
            r_cfg_addr  <= '0;
            r_cfg_wdata <= '0;
            r_cfg_ch    <= '0;
            r_halt_en   <= 1'b0;
            r_irq_en    <= 1'b0;
            r_s_nack    <= 1'b0;
            r_s_ovf     <= 1'b0;
            r_s_done    <= 1'b0;
            r_halted    <= 1'b0;
            r_last      <= '0;
            r_dcnt      <= '0;
            o_fx_q      <= '0;
            for (int i = 0; i < NDBG_A; i++) r_dbg[i] <= 8'(8'h80 + i);
        end else begin
            if (w_wsel) begin
                case (w_woff)
                    REG_CFG_DEVID: r_cfg_devid <= i_fx_data;
                    REG_CFG_ADDR:  r_cfg_addr  <= i_fx_data;
                    REG_CFG_WDATA: r_cfg_wdata <= i_fx_data;
                    REG_CFG_CH:    r_cfg_ch    <= i_fx_data[CHW-1:0];
                    REG_CTRL: begin
                        r_halt_en <= i_fx_data[CTRL_HALT];
                        r_irq_en  <= i_fx_data[CTRL_IRQEN];
                    end
                    default: ;
                endcase
                for (int i = 0; i < NDBG; i++)
                    if (w_woff == REG_DBG_BASE + 16'(i)) r_dbg[i] <= i_fx_data;
            end
            // Setting events override a same-edge clear.
            r_s_nack <= (r_s_nack & ~w_clr) | w_nack_ev;
            r_s_ovf  <= (r_s_ovf  & ~w_clr) | w_ovf_ev;
            r_s_done <= (r_s_done & ~w_clr) | w_done;
            if (w_nack_ev && r_halt_en) r_halted <= 1'b1;
            else if (w_resume)          r_halted <= 1'b0;
            if (w_done) begin
                r_dcnt <= r_dcnt + 8'd1;
                if (o_cmd_rw) r_last <= i_rsp_rdata;
            end
            o_fx_q <= w_rsel ? w_rdata : 8'h00;
        end
    end

    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = (r_state != S_IDLE);
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
        w_status[ST_NACK]  = r_s_nack;
        w_status[ST_OVF]   = r_s_ovf;
        w_status[ST_DONE]  = r_s_done;
        w_status[ST_HALTED] = r_halted;
    end

    always_comb begin
        w_rdata = '0;
        case (w_roff)
            REG_DEVID:     w_rdata = {2'b00, i_dev_id};
            REG_STATUS:    w_rdata = w_status;
            REG_CFG_DEVID: w_rdata = r_cfg_devid;
            REG_CFG_ADDR:  w_rdata = r_cfg_addr;
            REG_CFG_WDATA: w_rdata = r_cfg_wdata;
            REG_RDATA:     w_rdata = r_last;
            REG_CFG_CH:    w_rdata = {{(8-CHW){1'b0}}, r_cfg_ch};
            REG_CTRL:      w_rdata = {6'b0, r_irq_en, r_halt_en};
            REG_QCOUNT:    w_rdata = {{(8-CW){1'b0}}, w_count};
            REG_DCOUNT:    w_rdata = r_dcnt;
            default:       w_rdata = '0;
        endcase
        for (int i = 0; i < NDBG; i++)
            if (w_roff == REG_DBG_BASE + 16'(i)) w_rdata = r_dbg[i];
    end

endmodule

// File: tb/tb_iic_cmdq_reg.sv
// Self-checking bench for iic_cmdq_reg: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_iic_cmdq_reg;
    localparam int QDEPTH = 8;
    localparam int NCH    = 1;
    localparam int NDBG   = 8;
    localparam int CHW    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [5:0]     dev_id = 6'h15;
    logic           fx_wr = 1'b0, fx_rd = 1'b0;
    logic [21:0]    fx_waddr = '0, fx_raddr = '0;
    logic [7:0]     fx_data = '0;
    logic [7:0]     fx_q;
    logic           cmd_valid, cmd_rw;
    logic           cmd_ready = 1'b0;
    logic [CHW-1:0] cmd_ch;
    logic [7:0]     cmd_devid, cmd_addr, cmd_wdata;
    logic           rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0]     rsp_rdata = '0;
    logic           irq;

    iic_cmdq_reg #(.QDEPTH(QDEPTH), .NCH(NCH), .NDBG(NDBG)) dut (
        .i_clk_sys(clk), .i_rst(rst), .i_dev_id(dev_id),
        .i_fx_wr(fx_wr), .i_fx_waddr(fx_waddr), .i_fx_data(fx_data),
        .i_fx_rd(fx_rd), .i_fx_raddr(fx_raddr), .o_fx_q(fx_q),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_rw(cmd_rw),
        .o_cmd_ch(cmd_ch), .o_cmd_devid(cmd_devid), .o_cmd_addr(cmd_addr),
        .o_cmd_wdata(cmd_wdata), .i_rsp_valid(rsp_valid),
        .i_rsp_rdata(rsp_rdata), .i_rsp_nack(rsp_nack), .o_irq(irq)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic           rw;
        logic [CHW-1:0] ch;
        logic [7:0]     devid;
        logic [7:0]     addr;
        logic [7:0]     wdata;
    } cmd_t;

    cmd_t           mq[$];
    cmd_t           cur;
    bit             issuing, waiting, cur_in_q, mvalid;
    logic [7:0]     m_cfg_devid, m_cfg_addr, m_cfg_wdata, m_last, m_dcnt, m_q;
    logic [CHW-1:0] m_cfg_ch;
    bit             m_halt_en, m_irq_en, m_nack, m_ovf, m_done, m_halted;
    logic [7:0]     m_dbg [NDBG];

    function automatic logic [7:0] m_read(logic [15:0] off);
        logic [7:0] v;
        v = 8'h00;
        if (off >= 16'h80 && off < 16'h80 + 16'(NDBG)) v = m_dbg[int'(off) - 128];
        else case (off)
            16'h0: v = {2'b00, dev_id};
            16'h1: v = {1'b0, m_halted, m_done, m_ovf, m_nack,
                        mq.size() == QDEPTH, mq.size() == 0, issuing | waiting};
            16'h2: v = m_cfg_devid;
            16'h3: v = m_cfg_addr;
            16'h4: v = m_cfg_wdata;
            16'h5: v = m_last;
            16'h8: v = 8'(m_cfg_ch);
            16'h9: v = {6'b0, m_irq_en, m_halt_en};
            16'hA: v = 8'(mq.size());
            16'hB: v = m_dcnt;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_step();
        cmd_t nc, head;
        bit wsel, rsel, flush, clr, res, push, hs, fin, was_full, was_empty, oev, nev;
        logic [15:0] wo;
        if (rst) begin
            mq.delete();
            issuing = 0; waiting = 0; cur_in_q = 0;
            m_cfg_devid = 8'h42; m_cfg_addr = 0; m_cfg_wdata = 0; m_cfg_ch = 0;
            m_last = 0; m_dcnt = 0; m_q = 0;
            m_halt_en = 0; m_irq_en = 0;
            m_nack = 0; m_ovf = 0; m_done = 0; m_halted = 0;
            for (int i = 0; i < NDBG; i++) m_dbg[i] = 8'(128 + i);
            mvalid = 1;
        end else begin
            wsel = fx_wr && (fx_waddr[21:16] == dev_id);
            rsel = fx_rd && (fx_raddr[21:16] == dev_id);
            wo = fx_waddr[15:0];
            m_q = rsel ? m_read(fx_raddr[15:0]) : 8'h00;
            flush = wsel && wo == 16'hC && fx_data[0];
            clr   = wsel && wo == 16'hC && fx_data[1];
            res   = wsel && wo == 16'hC && fx_data[2];
            push  = wsel && (wo == 16'h6 || wo == 16'h7) && fx_data[0];
            nc.rw = (wo == 16'h7); nc.ch = m_cfg_ch; nc.devid = m_cfg_devid;
            nc.addr = m_cfg_addr; nc.wdata = m_cfg_wdata;
            hs  = issuing && cmd_ready;
            fin = waiting && rsp_valid;
            was_full  = mq.size() == QDEPTH;
            was_empty = mq.size() == 0;
            head = was_empty ? nc : mq[0];
            oev = 0;
            if (flush) begin
                mq.delete();
                cur_in_q = 0;
            end else begin
                if (hs && cur_in_q) mq.delete(0);
                if (push) begin
                    if (was_full) oev = 1;
                    else mq.push_back(nc);
                end
            end
            nev = fin && rsp_nack;
            if (fin) begin
                waiting = 0;
                m_dcnt = m_dcnt + 8'd1;
                if (cur.rw) m_last = rsp_rdata;
            end else if (hs) begin
                issuing = 0; waiting = 1;
            end else if (!issuing && !waiting && !was_empty && !m_halted && !flush) begin
                issuing = 1; cur = head; cur_in_q = 1;
            end
            if (nev && m_halt_en) m_halted = 1;
            else if (res) m_halted = 0;
            if (clr) begin m_nack = 0; m_ovf = 0; m_done = 0; end
            if (nev) m_nack = 1;
            if (oev) m_ovf = 1;
            if (fin) m_done = 1;
            if (wsel) begin
                case (wo)
                    16'h2: m_cfg_devid = fx_data;
                    16'h3: m_cfg_addr = fx_data;
                    16'h4: m_cfg_wdata = fx_data;
                    16'h8: m_cfg_ch = fx_data[CHW-1:0];
                    16'h9: begin m_halt_en = fx_data[0]; m_irq_en = fx_data[1]; end
                    default: ;
                endcase
                if (wo >= 16'h80 && wo < 16'h80 + 16'(NDBG)) m_dbg[int'(wo) - 128] = fx_data;
            end
        end
    endtask

    initial begin
        mvalid = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("model_fx_q", fx_q, m_q);
                chk("model_cmd_valid", cmd_valid, issuing);
                chk("model_irq", irq, m_irq_en & (m_done | m_nack | m_ovf));
                if (issuing)
                    chk("model_cmd", {cmd_rw, cmd_ch, cmd_devid, cmd_addr, cmd_wdata},
                        {cur.rw, cur.ch, cur.devid, cur.addr, cur.wdata});
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] off, input logic [7:0] d);
        fx_wr = 1; fx_waddr = {dev_id, off}; fx_data = d;
        tick();
        fx_wr = 0;
    endtask

    task automatic rdchk(input string nm, input logic [15:0] off, input logic [7:0] exp);
        fx_rd = 1; fx_raddr = {dev_id, off};
        tick();
        fx_rd = 0;
        chk(nm, fx_q, exp);
    endtask

    task automatic do_reset();
        rst = 1; cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; fx_wr = 0; fx_rd = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!cmd_valid && n < 20) begin tick(); n++; end
        chk("wait_cmd_valid", cmd_valid, 1'b1);
    endtask

    task automatic serve(input logic [7:0] rd, input logic nk);
        wait_valid();
        cmd_ready = 1; tick(); cmd_ready = 0;
        rsp_valid = 1; rsp_rdata = rd; rsp_nack = nk; tick();
        rsp_valid = 0; rsp_nack = 0;
    endtask

    logic [15:0] offs [19] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6,
                               16'h7, 16'h6, 16'h7, 16'h8, 16'h9, 16'hA, 16'hB,
                               16'hC, 16'h80, 16'h87, 16'h88, 16'h50};

    initial begin
        do_reset();
        // reset state
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_fx_q", fx_q, 8'h00);
        rdchk("rst_status", 16'h1, 8'h02);
        rdchk("rst_cfg_devid", 16'h2, 8'h42);
        rdchk("rd_devid", 16'h0, 8'h15);
        rdchk("rst_dbg7", 16'h87, 8'h87);

        // basic register access and selection
        wr(16'h2, 8'h5A);
        rdchk("cfg_devid_rw", 16'h2, 8'h5A);
        rdchk("unmapped_50", 16'h50, 8'h00);
        fx_rd = 1; fx_raddr = {~dev_id, 16'h2}; tick(); fx_rd = 0;
        chk("devid_mismatch", fx_q, 8'h00);

        // stalled handshake keeps the command stable
        do_reset();
        wr(16'h3, 8'h10); wr(16'h4, 8'h20); wr(16'h6, 8'h01);
        wr(16'h3, 8'h11); wr(16'h6, 8'h01);
        wr(16'h3, 8'h12); wr(16'h6, 8'h01);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", cmd_valid, 1'b1);
            chk("stall_cmd", {cmd_rw, cmd_addr, cmd_wdata}, {1'b0, 8'h10, 8'h20});
            tick();
        end
        rdchk("count_3", 16'hA, 8'd3);
        cmd_ready = 1; tick(); cmd_ready = 0;
        rdchk("count_2", 16'hA, 8'd2);

        // read command returns data and raises irq
        do_reset();
        wr(16'h9, 8'h02); wr(16'h3, 8'h33); wr(16'h7, 8'h01);
        serve(8'hC3, 1'b0);
        rdchk("last_rdata", 16'h5, 8'hC3);
        rdchk("done_count", 16'hB, 8'd1);
        rdchk("status_done", 16'h1, 8'h22);
        chk("irq_done", irq, 1'b1);

        // overflow at depth
        do_reset();
        repeat (QDEPTH + 1) wr(16'h6, 8'h01);
        rdchk("status_full_ovf", 16'h1, 8'h15);
        rdchk("count_full", 16'hA, 8'd8);
        wr(16'hC, 8'h02);
        rdchk("status_clr_ovf", 16'h1, 8'h05);

        // halt on nack, resume
        do_reset();
        wr(16'h9, 8'h01);
        wr(16'h3, 8'h11); wr(16'h6, 8'h01);
        wr(16'h3, 8'h22); wr(16'h6, 8'h01);
        serve(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("halted_no_issue", cmd_valid, 1'b0);
            tick();
        end
        rdchk("status_halted", 16'h1, 8'h68);
        wr(16'hC, 8'h04);
        wait_valid();
        chk("resume_addr", cmd_addr, 8'h22);

        // reset during wait abandons the command
        do_reset();
        wr(16'h9, 8'h02); wr(16'h6, 8'h01);
        wait_valid();
        cmd_ready = 1; tick(); cmd_ready = 0;
        rst = 1; tick(); rst = 0;
        chk("rstwait_valid", cmd_valid, 1'b0);
        chk("rstwait_irq", irq, 1'b0);
        chk("rstwait_q", fx_q, 8'h00);
        rsp_valid = 1; tick(); rsp_valid = 0;
        rdchk("rstwait_dcnt", 16'hB, 8'd0);
        rdchk("rstwait_status", 16'h1, 8'h02);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 500) == 0;
            fx_wr     = ($urandom % 3) == 0;
            fx_waddr  = {(($urandom % 10) == 0) ? ~dev_id : dev_id, offs[$urandom % 19]};
            fx_data   = 8'($urandom);
            if (fx_waddr[15:0] == 16'hC && ($urandom % 2) == 0) fx_data = 8'h04;
            fx_rd     = ($urandom % 2) == 0;
            fx_raddr  = {(($urandom % 10) == 0) ? ~dev_id : dev_id, offs[$urandom % 19]};
            cmd_ready = ($urandom % 2) == 0;
            rsp_valid = ($urandom % 4) == 0;
            rsp_rdata = 8'($urandom);
            rsp_nack  = ($urandom % 4) == 0;
            tick();
        end
        rst = 0; fx_wr = 0; fx_rd = 0; cmd_ready = 0; rsp_valid = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iic_cmdq_reg.md
IIC_CMDQ_REG -- requirements
Module: iic_cmdq_reg
Interface
REQ-001 Param QDEPTH, default 8, command-queue depth; power of 2, range 2..64.
REQ-002 Param NCH, default 1, number of IIC channels; range 1..8; CHW = max(1, clog2(NCH)).
REQ-003 Param NDBG, default 8, scratch debug registers at 0x80..0x80+NDBG-1; range 0..16.
REQ-004 clk_sys  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-005 dev_id  in  6  block select, compared with fx_waddr[21:16] and fx_raddr[21:16].
REQ-006 fx_wr in 1, fx_waddr in 22, fx_data in 8: bus write strobe, address and data.
REQ-007 fx_rd in 1, fx_raddr in 22: bus read strobe and address; fx_q out 8: read data.
REQ-008 cmd_valid out 1, cmd_ready in 1: command handshake to the IIC engine.
REQ-009 cmd_rw out 1 (1=read), cmd_ch out CHW, cmd_devid/cmd_addr/cmd_wdata out 8 each.
REQ-010 rsp_valid in 1, rsp_rdata in 8, rsp_nack in 1: single-cycle completion from the engine.
REQ-011 irq  out  1  level interrupt.
Function
REQ-012 Register map (fx_*addr[15:0]): 0x0 dev_id RO; 0x1 status RO; 0x2 cfg_devid RW (reset 0x42); 0x3 cfg_addr RW; 0x4 cfg_wdata RW; 0x5 last rdata RO; 0x6 push-write action; 0x7 push-read action; 0x8 cfg_ch RW (CHW bits, zero-extended on read); 0x9 ctrl RW ([0] halt_on_err, [1] irq_en); 0xA queue count RO; 0xB done count RO; 0xC action ([0] flush, [1] clear sticky, [2] resume).
REQ-013 Status bits: [0] busy (FSM not IDLE), [1] q_empty, [2] q_full, [3] nack sticky, [4] overflow sticky, [5] done sticky, [6] halted, [7] 0.
REQ-014 Reads: q updated the cycle after fx_rd with a selected address; q = 0 when not reading, when unselected, or for unmapped addresses.
REQ-015 Writes take effect on the clk_sys edge where fx_wr is high and selected; writes to RO/unmapped addresses are ignored.
REQ-016 Write to 0x6/0x7 with fx_data[0]=1 pushes {rw, cfg_ch, cfg_devid, cfg_addr, cfg_wdata} as held at that edge; fx_data[0]=0 does nothing.
REQ-017 Push while full: entry dropped, overflow sticky set, queue unchanged.
REQ-018 Push and pop in the same cycle: both occur, count unchanged; push into empty queue never pops the same cycle.
REQ-019 FSM IDLE->ISSUE when queue non-empty and not halted; ISSUE drives cmd_* from head, cmd_valid=1 held stable until cmd_ready; pop on cmd_valid&cmd_ready, go WAIT.
REQ-020 WAIT->IDLE on rsp_valid: done count +1 (8-bit wrap), done sticky set; read commands latch rsp_rdata to 0x5; write commands leave 0x5 unchanged.
REQ-021 rsp_nack at completion sets nack sticky; if halt_on_err, set halted; halted blocks IDLE->ISSUE until resume.
REQ-022 rsp_valid in IDLE or ISSUE is ignored.
REQ-023 Flush empties the queue next edge; an entry in ISSUE or WAIT completes normally; flush with simultaneous push: flush wins, push discarded.
REQ-024 Clear-sticky clears nack/overflow/done; a setting event on the same edge wins.
REQ-025 irq = irq_en & (done | nack | overflow sticky).
Reset
REQ-026 On rst high at a clk_sys edge: FSM IDLE, queue empty, stickies/halted/counters 0, cfg_devid 0x42, other cfg 0, dbg[i] 0x80+i, fx_q 0, cmd_valid 0, irq 0.
REQ-027 Reset during ISSUE or WAIT abandons the command; a later rsp_valid is ignored.
Structure
REQ-028 Package iic_pkg holds register offsets, status bit positions, ctrl/action bit positions and FSM state encoding.
REQ-029 Queue is sub-module iic_cmdq_fifo (synchronous, QDEPTH x 33 bits, pointer wrap, count output).
Verification
REQ-030 Write 0x2=0x5A, read 0x2 -> fx_q=0x5A one cycle later; read 0x50 -> 0x00; dev_id mismatch -> 0x00.
REQ-031 Push 3 writes, cmd_ready=0 for 4 cycles -> cmd_valid and cmd_* stable; count 3 then 2 after handshake.
REQ-032 Push read, rsp_valid with rdata=0xC3 -> 0x5 reads 0xC3, done count 1, irq=1 when irq_en=1.
REQ-033 QDEPTH=8: push 9 -> status q_full=1, overflow=1, count 8; clear-sticky -> overflow 0.
REQ-034 halt_on_err=1, nack on first of 2 entries -> halted, 2nd not issued until resume, then issued.
REQ-035 rst asserted in WAIT -> all outputs at reset values; subsequent rsp_valid -> done count stays 0.
